// File: rtl/ladybird_bus_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : ladybird_bus (interface)
//  Purpose  : Primary/secondary signal bundle of ladybird_bus. The shared data
//             line is tristate and is resolved here from the two enables.
//  Revision : 1.0 - initial release
// ============================================================================
interface ladybird_bus;
   logic        req;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        data_oe;
   logic        gnt;
   logic        data_gnt;
   logic [31:0] sdata;
   logic        sdata_oe;
   wire  [31:0] data;

   // primary drives the line only while requesting a write, secondary only while returning read data
   assign data = data_oe ? wdata : (sdata_oe ? sdata : 32'bz);

   modport primary   (output req, addr, wstrb, wdata, data_oe,
                      input  gnt, data_gnt, data);
   modport secondary (input  req, addr, wstrb, data,
                      output gnt, data_gnt, sdata, sdata_oe);
endinterface
`default_nettype wire

// File: rtl/ladybird_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : ladybird_bus_initiator
//  Purpose  : Primary side of ladybird_bus. Commands are queued in a small
//             FIFO and executed one at a time, one response per command,
//             strictly in order.
//  Options  : LADYBIRD_BUS_INITIATOR_TIMEOUT_EN - bounded bus waits with
//             rsp_err reporting; undefined = wait forever, rsp_err tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ladybird_bus_initiator #(
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire logic        clk,
   input  wire logic        nrst,
   input  wire logic        cmd_valid,
   output logic             cmd_ready,
   input  wire logic [31:0] cmd_addr,
   input  wire logic [31:0] cmd_wdata,
   input  wire logic [3:0]  cmd_wstrb,
   output logic             rsp_valid,
   input  wire logic        rsp_ready,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_write,
   output logic             rsp_err,
   output logic             busy,
   ladybird_bus.primary     bus
);

   localparam int AW = $clog2(CMD_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REQ       = 2'd1,
      S_WAIT_DATA = 2'd2,
      S_RESP      = 2'd3
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [31:0] r_fifo_addr  [CMD_DEPTH];
   logic [31:0] r_fifo_wdata [CMD_DEPTH];
   logic [3:0]  r_fifo_wstrb [CMD_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;

   // wrap bits differ with equal index -> full; identical pointers -> empty
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign cmd_ready = ~w_full;
   // a full FIFO refuses the push even when a pop happens in the same cycle
   assign w_push    = cmd_valid & ~w_full;

   // command storage, written at the tail
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr[AW-1:0]]  <= cmd_addr;
         r_fifo_wdata[r_wr_ptr[AW-1:0]] <= cmd_wdata;
         r_fifo_wstrb[r_wr_ptr[AW-1:0]] <= cmd_wstrb;
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // ------------------------------------------------- holding registers
   logic [31:0] r_h_addr;
   logic [31:0] r_h_wdata;
   logic [3:0]  r_h_wstrb;
   logic        w_h_write;

   assign w_h_write = |r_h_wstrb;

   // head entry moves into the holding registers when the FSM takes it
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_h_addr  <= '0;
         r_h_wdata <= '0;
         r_h_wstrb <= '0;
      end else if (w_pop) begin
         r_h_addr  <= r_fifo_addr[r_rd_ptr[AW-1:0]];
         r_h_wdata <= r_fifo_wdata[r_rd_ptr[AW-1:0]];
         r_h_wstrb <= r_fifo_wstrb[r_rd_ptr[AW-1:0]];
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t r_state;
   state_t w_state_next;
   logic   w_tmo_fire;

   // state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // next state, FIFO pop and bus drive
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      bus.req      = 1'b0;
      bus.addr     = '0;
      bus.wstrb    = '0;
      bus.wdata    = r_h_wdata;
      bus.data_oe  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_state_next = S_REQ;
               w_pop        = 1'b1;
            end
         end
         S_REQ: begin
            bus.req     = 1'b1;
            bus.addr    = r_h_addr;
            bus.wstrb   = r_h_wstrb;
            bus.data_oe = w_h_write;
            if (bus.gnt)         w_state_next = w_h_write ? S_RESP : S_WAIT_DATA;
            else if (w_tmo_fire) w_state_next = S_RESP;
         end
         S_WAIT_DATA: begin
            if (bus.data_gnt || w_tmo_fire) w_state_next = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               if (!w_empty) begin
                  w_state_next = S_REQ;
                  w_pop        = 1'b1;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- timeout
`ifdef LADYBIRD_BUS_INITIATOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] r_tmo_cnt;
   logic          r_rsp_err;

   // counts cycles spent waiting; every state change restarts it
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                        r_tmo_cnt <= '0;
      else if (w_state_next != r_state) r_tmo_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT_DATA)
                                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   assign w_tmo_fire = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                       ((r_state == S_REQ       && !bus.gnt) ||
                        (r_state == S_WAIT_DATA && !bus.data_gnt));

   // error flag set by an expired wait, cleared by any completed handshake
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)           r_rsp_err <= 1'b0;
      else if (w_tmo_fire) r_rsp_err <= 1'b1;
      else if ((r_state == S_REQ && bus.gnt) || (r_state == S_WAIT_DATA && bus.data_gnt))
                           r_rsp_err <= 1'b0;
   end

   assign rsp_err = r_rsp_err;
`else
   // the wait limit has no meaning when waits are unbounded
   wire [31:0] w_unused_timeout = 32'(TIMEOUT_CYCLES);

   assign w_tmo_fire = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   // ------------------------------------------------------------ response
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_write;

   // response payload captured as the bus transaction completes
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rsp_rdata <= '0;
         r_rsp_write <= 1'b0;
      end else if (r_state == S_REQ && bus.gnt && w_h_write) begin
         r_rsp_rdata <= '0;
         r_rsp_write <= 1'b1;
      end else if (r_state == S_WAIT_DATA && bus.data_gnt) begin
         r_rsp_rdata <= bus.data;
         r_rsp_write <= 1'b0;
      end else if (w_tmo_fire) begin
         r_rsp_rdata <= '0;
         r_rsp_write <= w_h_write;
      end
   end

   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_write = r_rsp_write;
   assign busy      = ~w_empty | (r_state != S_IDLE);

endmodule
`default_nettype wire
